// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port RAM arbiter
package mem_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RDATA  = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2.sv - two-way winner pick with last-grant register (round-robin or fixed priority)
module rr_pick2 #(
  parameter int PRIO_FIXED = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic grant_en,
  output logic win,
  output logic valid
);

  logic last_gnt;

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      win = (PRIO_FIXED != 0) ? 1'b0 : ~last_gnt;
    end else begin
      win = req1;
    end
  end

  // Reset to port 1 so that port 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (grant_en && valid) begin
      last_gnt <= win;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates CPU and DMA ports onto one single-port RAM via an IDLE/ACCESS/RDATA FSM
// Optional grant statistics counters enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int PRIO_FIXED = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  mem_cmd_t      cmd0,
  input  mem_cmd_t      cmd1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_write,
  input  logic [DW-1:0] ram_dout,
  output logic [15:0]   gnt_cnt0,
  output logic [15:0]   gnt_cnt1
);

  arb_state_t                       state;
  mem_cmd_t                         cmd_q;
  logic [AW-1:0]                    addr_q;
  logic [DW-1:0]                    wdata_q;
  logic [$clog2(NUM_PORTS)-1:0]     port_q;
  logic                             pick_win;
  logic                             pick_valid;
  logic                             in_access;
  logic                             in_rdata;

  rr_pick2 #(
    .PRIO_FIXED(PRIO_FIXED)
  ) u_pick (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .grant_en(state == IDLE),
    .win     (pick_win),
    .valid   (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cmd_q   <= MEM_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      port_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            port_q  <= pick_win;
            cmd_q   <= pick_win ? cmd1 : cmd0;
            addr_q  <= pick_win ? addr1 : addr0;
            wdata_q <= pick_win ? wdata1 : wdata0;
            state   <= ACCESS;
          end
        end
        ACCESS:  state <= (cmd_q == MEM_READ) ? RDATA : IDLE;
        RDATA:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode: every RAM-side and handshake output depends only on state and the latches.
  assign in_access = (state == ACCESS);
  assign in_rdata  = (state == RDATA);
  assign gnt0      = in_access && (port_q == 1'b0);
  assign gnt1      = in_access && (port_q == 1'b1);
  assign rvalid0   = in_rdata && (port_q == 1'b0);
  assign rvalid1   = in_rdata && (port_q == 1'b1);
  assign rdata     = in_rdata ? ram_dout : '0;
  assign ram_addr  = in_access ? addr_q : '0;
  assign ram_din   = in_access ? wdata_q : '0;
  assign ram_write = in_access && (cmd_q == MEM_WRITE);

`ifdef MEM_ARB_STATS_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt0 && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
      if (gnt1 && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`else
  assign gnt_cnt0 = 16'h0000;
  assign gnt_cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (round-robin and fixed-priority builds)
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;
`ifdef MEM_ARB_STATS_EN
  localparam logic [31:0] EXP_CNT0 = 32'd5;
  localparam logic [31:0] EXP_CNT1 = 32'd2;
`else
  localparam logic [31:0] EXP_CNT0 = 32'd0;
  localparam logic [31:0] EXP_CNT1 = 32'd0;
`endif

  logic          clk;
  logic          rst;
  logic          req0, req1;
  mem_cmd_t      cmd0, cmd1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_write;
  logic [15:0]   gnt_cnt0, gnt_cnt1;

  logic          fx_req0, fx_req1;
  logic          fx_gnt0, fx_gnt1, fx_rvalid0, fx_rvalid1, fx_ram_write;
  logic [DW-1:0] fx_rdata, fx_ram_din;
  logic [AW-1:0] fx_ram_addr;
  logic [15:0]   fx_cnt0, fx_cnt1;

  logic [DW-1:0] mem [0:255];

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .PRIO_FIXED(0)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_addr(ram_addr), .ram_din(ram_din), .ram_write(ram_write),
    .ram_dout(ram_dout), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .PRIO_FIXED(1)) u_fix (
    .clk(clk), .rst(rst),
    .req0(fx_req0), .req1(fx_req1), .cmd0(MEM_WRITE), .cmd1(MEM_WRITE),
    .addr0(8'h10), .addr1(8'h11), .wdata0(16'h0001), .wdata1(16'h0002),
    .gnt0(fx_gnt0), .gnt1(fx_gnt1), .rvalid0(fx_rvalid0), .rvalid1(fx_rvalid1),
    .rdata(fx_rdata), .ram_addr(fx_ram_addr), .ram_din(fx_ram_din), .ram_write(fx_ram_write),
    .ram_dout(16'h0000), .gnt_cnt0(fx_cnt0), .gnt_cnt1(fx_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input int p, input mem_cmd_t c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      req0 = 1'b1; cmd0 = c; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; cmd1 = c; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic release_all();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    cmd0 = MEM_NONE; cmd1 = MEM_NONE;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    fx_req0 = 1'b0; fx_req1 = 1'b0;
    step();
    step();
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_rvalid0", rvalid0, 0);
    check("rst_ram_write", ram_write, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_cnt0", gnt_cnt0, 0);
    rst = 1'b0;

    // 1: write then read back through port 0
    drive(0, MEM_WRITE, 8'h05, 16'hABCD);
    step();
    check("t1_gnt0", gnt0, 1);
    check("t1_gnt1", gnt1, 0);
    check("t1_wr", ram_write, 1);
    check("t1_addr", ram_addr, 8'h05);
    check("t1_din", ram_din, 16'hABCD);
    release_all();
    step();
    check("t1_idle_wr", ram_write, 0);
    check("t1_idle_addr", ram_addr, 0);
    drive(1, MEM_WRITE, 8'h06, 16'h1234);
    step();
    check("t1_gnt1_wr", gnt1, 1);
    release_all();
    step();
    drive(0, MEM_READ, 8'h05, 16'h0000);
    step();
    check("t1r_gnt0", gnt0, 1);
    check("t1r_wr", ram_write, 0);
    check("t1r_addr", ram_addr, 8'h05);
    release_all();
    step();
    check("t1r_rvalid0", rvalid0, 1);
    check("t1r_rvalid1", rvalid1, 0);
    check("t1r_rdata", rdata, 16'hABCD);
    step();
    check("t1r_rvalid0_end", rvalid0, 0);

    // 2: simultaneous reads after reset alternate starting with port 0
    do_reset();
    drive(0, MEM_READ, 8'h05, 16'h0000);
    drive(1, MEM_READ, 8'h06, 16'h0000);
    step();
    check("t2_gnt0", gnt0, 1);
    check("t2_gnt1_lose", gnt1, 0);
    req0 = 1'b0;
    step();
    check("t2_rvalid0", rvalid0, 1);
    check("t2_rdata0", rdata, 16'hABCD);
    step();
    check("t2_idle_gnt1", gnt1, 0);
    step();
    check("t2_gnt1", gnt1, 1);
    check("t2_gnt0_off", gnt0, 0);
    req1 = 1'b0;
    step();
    check("t2_rvalid1", rvalid1, 1);
    check("t2_rdata1", rdata, 16'h1234);
    step();
    drive(0, MEM_READ, 8'h05, 16'h0000);
    drive(1, MEM_READ, 8'h06, 16'h0000);
    step();
    check("t2b_gnt0", gnt0, 1);
    check("t2b_gnt1_lose", gnt1, 0);
    req0 = 1'b0;
    step();
    step();
    step();
    check("t2b_gnt1", gnt1, 1);
    req1 = 1'b0;
    step();
    step();
    drive(0, MEM_WRITE, 8'h08, 16'h5555);
    step();
    check("t2c_single_gnt0", gnt0, 1);
    release_all();
    step();
    drive(0, MEM_WRITE, 8'h09, 16'h6666);
    drive(1, MEM_WRITE, 8'h0A, 16'h7777);
    step();
    check("t2c_tie_gnt1", gnt1, 1);
    check("t2c_tie_gnt0", gnt0, 0);
    req1 = 1'b0;
    step();
    step();
    check("t2c_next_gnt0", gnt0, 1);
    req0 = 1'b0;
    step();

    // 3: fixed priority, both requests held for four grants
    fx_req0 = 1'b1;
    fx_req1 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("t3_fx_gnt0_%0d", i), fx_gnt0, (i % 2 == 1) ? 1 : 0);
      check($sformatf("t3_fx_gnt1_%0d", i), fx_gnt1, 0);
    end
    fx_req0 = 1'b0;
    fx_req1 = 1'b0;
    step();
    step();

    // 4: NONE and reserved commands are granted without write or rvalid
    drive(1, MEM_NONE, 8'h07, 16'hFFFF);
    step();
    check("t4_gnt1", gnt1, 1);
    check("t4_wr", ram_write, 0);
    release_all();
    step();
    check("t4_rvalid1", rvalid1, 0);
    check("t4_addr_idle", ram_addr, 0);
    drive(0, MEM_WRITE, 8'h0B, 16'h1111);
    step();
    check("t4_idle_regrant", gnt0, 1);
    release_all();
    step();
    drive(1, MEM_RSVD, 8'h07, 16'hFFFF);
    step();
    check("t4r_gnt1", gnt1, 1);
    check("t4r_wr", ram_write, 0);
    release_all();
    step();
    check("t4r_rvalid1", rvalid1, 0);
    step();

    // 5: reset during the ACCESS cycle of a read
    drive(0, MEM_READ, 8'h05, 16'h0000);
    step();
    check("t5_gnt0", gnt0, 1);
    rst = 1'b1;
    release_all();
    step();
    check("t5_rvalid0", rvalid0, 0);
    check("t5_gnt0_rst", gnt0, 0);
    check("t5_addr_rst", ram_addr, 0);
    check("t5_rdata_rst", rdata, 0);
    check("t5_cnt0_rst", gnt_cnt0, 0);
    drive(1, MEM_WRITE, 8'h0C, 16'h2222);
    step();
    check("t5_gnt1_in_rst", gnt1, 0);
    check("t5_rvalid0_b", rvalid0, 0);
    rst = 1'b0;
    step();
    check("t5_gnt1_after", gnt1, 1);
    check("t5_rvalid0_c", rvalid0, 0);
    release_all();
    step();
    check("t5_rvalid0_d", rvalid0, 0);

    // 6: grant statistics
    do_reset();
    check("t6_cnt0_zero", gnt_cnt0, 0);
    check("t6_cnt1_zero", gnt_cnt1, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, MEM_WRITE, 8'h20 + 8'(i), 16'h3000 + 16'(i));
      step();
      release_all();
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, MEM_WRITE, 8'h30 + 8'(i), 16'h4000 + 16'(i));
      step();
      release_all();
      step();
    end
    check("t6_cnt0", gnt_cnt0, EXP_CNT0);
    check("t6_cnt1", gnt_cnt1, EXP_CNT1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
